// File: rtl/cpu_pkg.sv
// Shared CPU types: issuer FSM states, halt encoding,
// and instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE,
    HALT,
    ERROR
  } issuer_state_t;

  localparam logic [15:0] HALT_WORD = 16'hE000;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int OP_MSB     = 12;
  localparam int OP_LSB     = 11;

endpackage

// File: rtl/instr_issuer_if.sv
// Issuer bus: imem_addr/imem_data to memory, instr/opcode/op/s/w to controller.
// master = issuer side, slave = memory + fsm controller side.
interface instr_issuer_if #(
  parameter int AW = 8
);

  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [15:0]   instr;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic          s;
  logic          w;

  modport master (
    output imem_addr,
    output instr,
    output opcode,
    output op,
    output s,
    input  imem_data,
    input  w
  );

  modport slave (
    input  imem_addr,
    input  instr,
    input  opcode,
    input  op,
    input  s,
    output imem_data,
    output w
  );

endinterface

// File: rtl/instr_issuer_issue_watchdog.sv
// Cycle watchdog for handshake waits: clear, enable, expired.
// expired is high during the TIMEOUT-th cycle since the last clear.
module issue_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instr_issuer.sv
// Steps PC through imem, latches instr, pulses s and waits on w from the controller.
// Ports: clk, reset, run, prog_len, bus (master), busy, done, error, retired.
module instr_issuer
  import cpu_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic [AW:0]    prog_len,
  instr_issuer_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [AW:0]    retired
);

  issuer_state_t state;

  logic          wd_clr;
  logic          wd_en;
  logic          wd_exp;
  logic [AW:0]   pc_nxt;

  assign bus.opcode = bus.instr[OPCODE_MSB:OPCODE_LSB];
  assign bus.op     = bus.instr[OP_MSB:OP_LSB];

  // PC is extended by one bit so prog_len == 2**AW is reachable.
  assign pc_nxt = {1'b0, bus.imem_addr} + (AW+1)'(1);

  // Count only while waiting; restart on the ack -> done hand-over.
  assign wd_en  = (state == WAIT_ACK) || (state == WAIT_DONE);
  assign wd_clr = !wd_en || ((state == WAIT_ACK) && !bus.w);

  issue_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clr),
    .enable  (wd_en),
    .expired (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.imem_addr <= '0;
      bus.instr     <= '0;
      bus.s         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      retired       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run && (prog_len == '0)) begin
            state   <= HALT;
            retired <= '0;
            done    <= 1'b1;
          end else if (run && bus.w) begin
            state         <= FETCH;
            bus.imem_addr <= '0;
            retired       <= '0;
            busy          <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          state     <= START;
          bus.instr <= bus.imem_data;
          bus.s     <= 1'b1;
        end
        START: begin
          state <= WAIT_ACK;
          bus.s <= 1'b0;
        end
        WAIT_ACK: begin
          if (!bus.w) begin
            state <= WAIT_DONE;
          end else if (wd_exp) begin
            state <= ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.w) begin
            retired <= retired + (AW+1)'(1);
            // A halt word stops the PC on itself.
            if (bus.instr == HALT_WORD) begin
              state <= HALT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              bus.imem_addr <= pc_nxt[AW-1:0];
              if (pc_nxt == prog_len) begin
                state <= HALT;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end else if (wd_exp) begin
            state <= ERROR;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        HALT: begin
          if (!run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        ERROR: begin
          bus.s <= 1'b0;
          busy  <= 1'b0;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: memory + controller models,
// immediate-assertion checks at negedge.
module tb_instr_issuer;

  localparam int AW = 8;
  localparam int TO = 8;

  logic          clk;
  logic          reset;
  logic          run;
  logic [AW:0]   prog_len;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   retired;

  instr_issuer_if #(.AW(AW)) bus ();

  instr_issuer #(
    .AW      (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .prog_len (prog_len),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:255];

  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  // Controller model: after s, drop w ack_dly cycles later, hold low low_len cycles.
  logic noack;
  int   ack_dly;
  int   low_len;
  int   ph;

  always @(posedge clk) begin
    if (reset) begin
      ph    <= 0;
      bus.w <= 1'b1;
    end else if (ph == 0) begin
      if (bus.s && !noack) ph <= 1;
    end else begin
      if (ph == ack_dly) bus.w <= 1'b0;
      if (ph == ack_dly + low_len) begin
        bus.w <= 1'b1;
        ph    <= 0;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  int cyc;
  int s_cyc [$];
  int s_addr [$];
  int s_ins [$];
  int max_addr;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.s === 1'b1) begin
      s_cyc.push_back(cyc);
      s_addr.push_back(int'(bus.imem_addr));
      s_ins.push_back(int'(bus.instr));
    end
    if (busy === 1'b1 && int'(bus.imem_addr) > max_addr)
      max_addr = int'(bus.imem_addr);
  end

  int cmp;
  int mism;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    s_cyc.delete();
    s_addr.delete();
    s_ins.delete();
    max_addr = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) break;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_s(input int n, input string tag);
    int k;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.s === 1'b1) k++;
      if (k == n) break;
    end
    chk(tag, 32'(k), 32'(n));
  endtask

  initial begin
    int n;
    cmp      = 0;
    mism     = 0;
    cyc      = 0;
    max_addr = 0;
    noack    = 1'b0;
    ack_dly  = 1;
    low_len  = 3;
    reset    = 1'b1;
    run      = 1'b0;
    prog_len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (2) @(negedge clk);

    chk("rst_s", 32'(bus.s), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    reset = 1'b0;

    // 1: single MOV R0,#45
    mem[0]   = 16'hD02D;
    prog_len = 9'd1;
    clr_mon();
    @(negedge clk);
    run = 1'b1;
    wait_done("t1_done");
    chk("t1_ret", 32'(retired), 32'd1);
    chk("t1_spulses", 32'(s_cyc.size()), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_instr", 32'(bus.instr), 32'hD02D);
    chk("t1_opcode", 32'(bus.opcode), 32'd6);
    chk("t1_op", 32'(bus.op), 32'd2);
    chk("t1_addr", 32'(bus.imem_addr), 32'd1);
    run = 1'b0;
    @(negedge clk);
    chk("t1_done_clr", 32'(done), 32'd0);

    // 2: three instructions, w low 1 cycle after s for 4 cycles
    mem[0]   = 16'h2000;
    mem[1]   = 16'h4801;
    mem[2]   = 16'h6802;
    prog_len = 9'd3;
    low_len  = 4;
    clr_mon();
    run = 1'b1;
    wait_done("t2_done");
    chk("t2_ret", 32'(retired), 32'd3);
    chk("t2_spulses", 32'(s_cyc.size()), 32'd3);
    if (s_cyc.size() == 3) begin
      chk("t2_gap01", 32'(s_cyc[1] - s_cyc[0]), 32'd9);
      chk("t2_gap12", 32'(s_cyc[2] - s_cyc[1]), 32'd9);
      chk("t2_addr0", 32'(s_addr[0]), 32'd0);
      chk("t2_addr1", 32'(s_addr[1]), 32'd1);
      chk("t2_addr2", 32'(s_addr[2]), 32'd2);
      chk("t2_ins1", 32'(s_ins[1]), 32'h4801);
    end
    run = 1'b0;
    @(negedge clk);

    // 3: no ack -> timeout
    noack    = 1'b1;
    prog_len = 9'd1;
    run      = 1'b1;
    wait_s(1, "t3_s_seen");
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (error === 1'b1) break;
    end
    chk("t3_err_lat", 32'(n), 32'(TO + 1));
    chk("t3_err", 32'(error), 32'd1);
    chk("t3_s", 32'(bus.s), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_done", 32'(done), 32'd0);
    run = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_sticky", 32'(error), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t3_err_rst", 32'(error), 32'd0);
    noack = 1'b0;

    // 4: halt word at address 1
    mem[0]   = 16'h2000;
    mem[1]   = 16'hE000;
    mem[2]   = 16'h4000;
    prog_len = 9'd5;
    low_len  = 2;
    clr_mon();
    @(negedge clk);
    run = 1'b1;
    wait_done("t4_done");
    chk("t4_ret", 32'(retired), 32'd2);
    chk("t4_spulses", 32'(s_cyc.size()), 32'd2);
    chk("t4_maxaddr", 32'(max_addr), 32'd1);
    chk("t4_addr", 32'(bus.imem_addr), 32'd1);
    run = 1'b0;
    @(negedge clk);

    // 5: reset inside WAIT_DONE of the second instruction
    mem[1]   = 16'h4801;
    prog_len = 9'd3;
    low_len  = 4;
    run      = 1'b1;
    wait_s(2, "t5_s2");
    repeat (3) @(negedge clk);
    chk("t5_pre_w", 32'(bus.w), 32'd0);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_addr", 32'(bus.imem_addr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_s", 32'(bus.s), 32'd0);
    chk("t5_addr", 32'(bus.imem_addr), 32'd0);
    chk("t5_instr", 32'(bus.instr), 32'd0);
    chk("t5_opcode", 32'(bus.opcode), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_err", 32'(error), 32'd0);
    chk("t5_ret", 32'(retired), 32'd0);
    clr_mon();
    reset = 1'b0;
    wait_done("t5_rerun_done");
    chk("t5_ret3", 32'(retired), 32'd3);
    if (s_cyc.size() > 0) begin
      chk("t5_first_addr", 32'(s_addr[0]), 32'd0);
      chk("t5_first_ins", 32'(s_ins[0]), 32'h2000);
    end
    run = 1'b0;
    @(negedge clk);

    // 6: empty program
    prog_len = 9'd0;
    clr_mon();
    run = 1'b1;
    @(negedge clk);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ret", 32'(retired), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_nos", 32'(s_cyc.size()), 32'd0);
    chk("t6_hold", 32'(done), 32'd1);
    run = 1'b0;
    @(negedge clk);
    chk("t6_done_clr", 32'(done), 32'd0);
    chk("t6_busy_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
